bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Parametrised N-digit BCD up/down counter with an internal tick prescaler, synchronous load, and a selectable wrap or saturate mode. It drives display blocks such as the HC595 segment scanner with packed BCD digits directly, so no binary-to-BCD converter is needed downstream. It generalises the fixed 8-digit, 100 ms, up-only decimal generator used by the display demos.

## Interface
- `DIGITS`, 8: number of BCD digits, 1..8.
- `TICK_MAX`, 4_999_999: prescaler terminal count. The tick period is TICK_MAX+1 clocks (100 ms at 50 MHz).
- `TICK_W`, 23: prescaler width. It must satisfy TICK_MAX < 2^TICK_W.
- `WRAP`, 1: 1 = wrap at the limits, 0 = saturate at the limits.

Ports:
- `clk`  in  1  system clock. This is the only clock.
- `rst`  in  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- `en`  in  1  count enable. When low, the prescaler and the count both freeze.
- `up`  in  1  direction: 1 = increment, 0 = decrement. Sampled at each tick.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  4*DIGITS  packed BCD load value. Digit 0 is in [3:0].
- `bcd`  out  4*DIGITS  packed BCD count. Digit 0 (least significant) is in [3:0].
- `tick`  out  1  one-cycle pulse. It is high in the cycle the new `bcd` value first appears.
- `wrap`  out  1  one-cycle pulse, coincident with `tick`, when the count rolls over (all-9s to 0, or 0 to all-9s). It is always 0 when WRAP=0.
- `at_max`  out  1  level, high while `bcd` is all 9s.
- `at_min`  out  1  level, high while `bcd` is all 0s.

## Operation
- Prescaler `cnt`, TICK_W bits:
  - When `en`=1, it counts 0..TICK_MAX and then returns to 0.
  - When `en`=0, it holds its value.
  - The step event is `cnt==TICK_MAX && en`.
- On a step event:
  - Up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. The carry ripples through contiguous 9s.
  - Down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Limits:
  - Up at all 9s: WRAP=1 gives all 0s with `wrap`=1. WRAP=0 holds all 9s, `wrap`=0, and `tick` still pulses.
  - Down at all 0s: WRAP=1 gives all 9s with `wrap`=1. WRAP=0 holds all 0s.
- Load:
  - `load`=1 writes `load_val` into `bcd` on the next edge and clears `cnt` to 0.
  - Any load digit greater than 9 is clamped to 9.
  - Load works regardless of `en`.
  - A load produces no `tick` and no `wrap`.
- Priority, highest first: `rst`, then `load`, then step event, then hold.
  - Load in the same cycle as a step event: the load wins, the step is discarded, and `cnt` restarts at 0.
- A change of `up` takes effect only at the next step event. There is no side effect on `cnt`.
- `at_max` and `at_min` are combinational decodes of the `bcd` register. With DIGITS=1 they decode 9 and 0 respectively.
- All arithmetic is per-digit 4-bit BCD. The count never holds a non-BCD digit.

## Timing
- Reset values: `bcd`=0, `cnt`=0, `tick`=0, `wrap`=0, `at_min`=1, `at_max`=0.
- With `en` held high from reset release, the first `tick` and `bcd` update occur TICK_MAX+1 clocks after the first active edge. Subsequent ticks follow every TICK_MAX+1 clocks.
- `tick` and `wrap` are registered. They rise on the same edge that updates `bcd` and stay high for exactly one cycle.
- Load latency is 1 cycle: `bcd`=`load_val` on the edge after `load` is sampled high. After a load, the next tick comes TICK_MAX+1 clocks later if `en` stays high.
- If `en` drops for k cycles, the next tick is delayed by exactly k cycles. The prescaler phase is preserved.
- `rst` asserted mid-operation clears all state immediately, without waiting for `clk`. Counting resumes from 0 with a full period after `rst` falls.

## Test plan
Unless stated otherwise, the bench uses DIGITS=3 and TICK_MAX=3.
- Count up, wrap: reset, then `en`=1, `up`=1 for 4000 clocks.
  - `tick` every 4 clocks.
  - `bcd` runs 000, 001 ... 009, 010 ... 999, 000.
  - `wrap`=1 only on the 999 to 000 transition.
  - `at_max` is high exactly while `bcd` is 999.
- Count down from 0, wrap: `up`=0 from reset.
  - The first tick gives `bcd`=999 with `wrap`=1.
  - The next tick gives 998, then 990 goes to 989 (borrow ripple).
- Saturate, WRAP=0:
  - Load 998 with `up`=1. After two ticks `bcd`=999 and it holds; `tick` keeps pulsing; `wrap` stays 0.
  - Then `up`=0. The next tick gives 998.
- Load behaviour:
  - Load 0x1F5. `bcd`=195 one cycle later (digit F clamped to 9).
  - `load` asserted on the step-event cycle: `bcd`=`load_val`, no `tick`, and the next tick comes 4 clocks later.
- Enable and reset:
  - Drop `en` for 5 cycles mid-period: the tick is delayed by 5 cycles and `bcd` holds.
  - Assert `rst` asynchronously between edges: `bcd`=000 and `at_min`=1 immediately.
- Default parameters, sampled run: the tick spacing is 5_000_000 clocks.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// N-digit packed-BCD up/down counter advanced by an internal tick prescaler,
// with synchronous clamped load and wrap-or-saturate behaviour at the limits.
module bcd_tick_counter #(
    parameter int DIGITS   = 8,
    parameter int TICK_MAX = 4_999_999,
    parameter int TICK_W   = 23,
    parameter int WRAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  wrap,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);

    logic [TICK_W-1:0]   cnt;
    logic                step;
    logic [4*DIGITS-1:0] stepped;
    logic                carry;
    logic [3:0]          digit;
    logic [4*DIGITS-1:0] next_bcd;
    logic                next_wrap;
    logic [4*DIGITS-1:0] load_clamped;
    logic [3:0]          load_digit;

    assign step = en && (cnt == TICK_LAST);

    // Carry/borrow ripples through contiguous 9s (up) or 0s (down); a carry
    // out of the top digit means the count rolled over.
    always_comb begin
        stepped = bcd;
        carry   = 1'b1;
        digit   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = bcd[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (digit >= 4'd9) begin
                        stepped[4*i +: 4] = '0;
                    end else begin
                        stepped[4*i +: 4] = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        next_bcd  = stepped;
        next_wrap = carry;
        if (carry && (WRAP == 0)) begin
            next_bcd  = bcd;
            next_wrap = 1'b0;
        end
    end

    always_comb begin
        load_clamped = '0;
        load_digit   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            load_digit = load_val[4*i +: 4];
            load_clamped[4*i +: 4] = (load_digit > 4'd9) ? 4'd9 : load_digit;
        end
    end

    always_comb begin
        at_max = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd9) begin
                at_max = 1'b0;
            end
        end
    end

    assign at_min = (bcd == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bcd  <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            bcd  <= load_clamped;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (step) begin
            cnt  <= '0;
            bcd  <= next_bcd;
            tick <= 1'b1;
            wrap <= next_wrap;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Drives a wrapping and a saturating 3-digit instance with shared stimulus and
// compares both against an integer-arithmetic reference of the counter.
module tb_bcd_tick_counter;

    localparam int D    = 3;
    localparam int TMAX = 3;
    localparam int MAXV = 999;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           up = 1'b1;
    logic           load = 1'b0;
    logic [4*D-1:0] load_val = '0;

    logic [4*D-1:0] bcd_w, bcd_s;
    logic           tick_w, tick_s, wrap_w, wrap_s;
    logic           at_max_w, at_max_s, at_min_w, at_min_s;

    int tests_run = 0;
    int tests_failed = 0;

    // reference state: plain integer counts and prescaler phase
    int m_w = 0, m_s = 0, ph = 0;
    logic e_tick = 1'b0, e_wrap = 1'b0;

    always #5 clk = ~clk;

    bcd_tick_counter #(.DIGITS(D), .TICK_MAX(TMAX), .TICK_W(4), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd_w), .tick(tick_w), .wrap(wrap_w), .at_max(at_max_w), .at_min(at_min_w)
    );

    bcd_tick_counter #(.DIGITS(D), .TICK_MAX(TMAX), .TICK_W(4), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd_s), .tick(tick_s), .wrap(wrap_s), .at_max(at_max_s), .at_min(at_min_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int n);
        logic [4*D-1:0] r;
        int v;
        v = n;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*D-1:0] v);
        int n;
        int d;
        n = 0;
        for (int i = D - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            n = n * 10 + d;
        end
        return n;
    endfunction

    task automatic model_edge();
        if (load) begin
            m_w = clamp_val(load_val);
            m_s = m_w;
            ph = 0;
            e_tick = 1'b0;
            e_wrap = 1'b0;
        end else if (en && ph == TMAX) begin
            ph = 0;
            e_tick = 1'b1;
            e_wrap = 1'b0;
            if (up) begin
                if (m_w == MAXV) begin m_w = 0; e_wrap = 1'b1; end
                else m_w = m_w + 1;
                if (m_s < MAXV) m_s = m_s + 1;
            end else begin
                if (m_w == 0) begin m_w = MAXV; e_wrap = 1'b1; end
                else m_w = m_w - 1;
                if (m_s > 0) m_s = m_s - 1;
            end
        end else begin
            e_tick = 1'b0;
            e_wrap = 1'b0;
            if (en) ph = ph + 1;
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_s = 0; ph = 0;
        e_tick = 1'b0; e_wrap = 1'b0;
    endtask

    task automatic compare_all();
        check("bcd_w", 32'(bcd_w), 32'(to_bcd(m_w)));
        check("bcd_s", 32'(bcd_s), 32'(to_bcd(m_s)));
        check("tick_w", 32'(tick_w), 32'(e_tick));
        check("tick_s", 32'(tick_s), 32'(e_tick));
        check("wrap_w", 32'(wrap_w), 32'(e_wrap));
        check("wrap_s", 32'(wrap_s), 32'(0));
        check("at_max_w", 32'(at_max_w), 32'(m_w == MAXV));
        check("at_max_s", 32'(at_max_s), 32'(m_s == MAXV));
        check("at_min_w", 32'(at_min_w), 32'(m_w == 0));
        check("at_min_s", 32'(at_min_s), 32'(m_s == 0));
    endtask

    // one clock: model sees the inputs present at the edge, outputs sampled 1ns later
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_bcd_w", 32'(bcd_w), 32'(0));
        check("async_rst_bcd_s", 32'(bcd_s), 32'(0));
        check("async_rst_at_min", 32'(at_min_w), 32'(1));
        check("async_rst_tick", 32'(tick_w), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        @(posedge clk);
        #1;
        compare_all();
        check("rst_at_min", 32'(at_min_w), 32'(1));
        check("rst_at_max", 32'(at_max_w), 32'(0));
        rst = 1'b0;

        // full up-count cycle through 999 and back to 000
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 4000; i++) cycle();
        check("up_wrapped_home", 32'(bcd_w), 32'(0));

        // down from zero: wraps to 999, then borrow ripples
        async_reset();
        up = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("down_first_tick", 32'(bcd_w), 32'h999);
        check("down_first_wrap", 32'(wrap_w), 32'(1));
        for (int i = 0; i < 60; i++) cycle();

        // saturate/wrap at top after loading 998
        load_val = 12'h998;
        load = 1'b1;
        cycle();
        load = 1'b0;
        up = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_hold", 32'(bcd_s), 32'h999);
        up = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("sat_down", 32'(bcd_s), 32'h998);

        // clamped load, independent of enable
        en = 1'b0;
        load_val = 12'h1F5;
        load = 1'b1;
        cycle();
        load = 1'b0;
        check("load_clamp", 32'(bcd_w), 32'h195);
        en = 1'b1;

        // load on the step-event cycle
        for (int i = 0; i < 8 && ph != TMAX; i++) cycle();
        load_val = 12'h042;
        load = 1'b1;
        cycle();
        load = 1'b0;
        check("load_on_step_tick", 32'(tick_w), 32'(0));
        for (int i = 0; i < 4; i++) cycle();
        check("load_on_step_next", 32'(tick_w), 32'(1));

        // enable gap mid-period
        up = 1'b1;
        cycle();
        cycle();
        en = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        en = 1'b1;
        for (int i = 0; i < 8; i++) cycle();

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) up = $urandom_range(0, 1) != 0;
            load = ($urandom_range(0, 49) == 0);
            load_val = 12'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end
            cycle();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
